linear_network_unicast_seq_1x16: RTL and testbench

Pipelined 1-input, 16-output linear unicast network. A packet enters at node 0 carrying a destination tag and hops one node per clock along a chain of registered stages. The node whose index equals the tag delivers the packet on its output port and stops forwarding it. It is used as the distribution fabric from a single producer to 16 consumer PEs.

---
 rtl/linear_network_unicast_seq_1x16_pkg.sv | 23 ++
 rtl/linear_network_node.sv | 61 ++++++
 rtl/linear_network_unicast_seq_1x16.sv | 66 ++++++
 tb/tb_linear_network_unicast_seq_1x16.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/linear_network_unicast_seq_1x16_pkg.sv
`default_nettype none
// ============================================================================
// Module      : linear_network_unicast_seq_1x16_pkg
// Description : Shared defaults and stage-record type for the 1x16 linear
//               unicast distribution chain.
// Revision    : 1.0 - initial release
// ============================================================================
package linear_network_unicast_seq_1x16_pkg;

    localparam int c_data_width    = 32;
    localparam int c_num_node      = 16;
    localparam int c_command_width = $clog2(c_num_node);

    // One chain stage as it sits in its register: valid flag, destination
    // tag and payload.
    typedef struct packed {
        logic                       valid;
        logic [c_command_width-1:0] tag;
        logic [c_data_width-1:0]    data;
    } stage_t;

endpackage : linear_network_unicast_seq_1x16_pkg
`default_nettype wire

// File: rtl/linear_network_node.sv
`default_nettype none
// ============================================================================
// Module      : linear_network_node
// Description : One hop of the linear unicast chain. Registers the incoming
//               stage, delivers locally when the tag matches NODE_ID and
//               otherwise forwards the packet to the next hop.
// Revision    : 1.0 - initial release
// ============================================================================
module linear_network_node #(
    parameter int DATA_WIDTH    = 32,
    parameter int COMMAND_WIDTH = 4,
    parameter int NODE_ID       = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_valid,
    input  logic [COMMAND_WIDTH-1:0] i_tag,
    input  logic [DATA_WIDTH-1:0]    i_data,
    output logic                     o_dlv_valid,
    output logic [DATA_WIDTH-1:0]    o_dlv_data,
    output logic                     o_fwd_valid,
    output logic [COMMAND_WIDTH-1:0] o_fwd_tag,
    output logic [DATA_WIDTH-1:0]    o_fwd_data
);

    localparam logic [COMMAND_WIDTH-1:0] c_node_tag = COMMAND_WIDTH'(NODE_ID);

    logic                     r_valid;
    logic [COMMAND_WIDTH-1:0] r_tag;
    logic [DATA_WIDTH-1:0]    r_data;

    logic                     w_hit;
    logic                     w_pass;

    // Stage register; upstream already zeroes tag/data of bubbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_tag   <= '0;
            r_data  <= '0;
        end else begin
            r_valid <= i_valid;
            r_tag   <= i_tag;
            r_data  <= i_data;
        end
    end

    assign w_hit  = r_valid & (r_tag == c_node_tag);
    assign w_pass = r_valid & (r_tag != c_node_tag);

    // Local delivery: payload only visible while the pulse is up.
    assign o_dlv_valid = w_hit;
    assign o_dlv_data  = w_hit ? r_data : '0;

    // Forwarding: a delivered packet stops here, leaving a clean bubble.
    assign o_fwd_valid = w_pass;
    assign o_fwd_tag   = w_pass ? r_tag  : '0;
    assign o_fwd_data  = w_pass ? r_data : '0;

endmodule : linear_network_node
`default_nettype wire

// File: rtl/linear_network_unicast_seq_1x16.sv
`default_nettype none
// ============================================================================
// Module      : linear_network_unicast_seq_1x16
// Description : Pipelined 1-input / NUM_NODE-output linear unicast network.
//               Packets enter at node 0 and hop one node per clock until the
//               node matching their destination tag delivers them.
// Revision    : 1.0 - initial release
// ============================================================================
module linear_network_unicast_seq_1x16
    import linear_network_unicast_seq_1x16_pkg::*;
#(
    parameter int DATA_WIDTH    = c_data_width,
    parameter int NUM_NODE      = c_num_node,
    parameter int COMMAND_WIDTH = $clog2(NUM_NODE)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_valid,
    input  logic [DATA_WIDTH-1:0]          i_data_bus,
    input  logic                           i_en,
    input  logic [COMMAND_WIDTH-1:0]       i_cmd,
    output logic [NUM_NODE-1:0]            o_valid,
    output logic [NUM_NODE*DATA_WIDTH-1:0] o_data_bus
);

    // Index k is the value node k loads on the next edge; index NUM_NODE is
    // what the last node would hand on, which has no consumer.
    logic                     w_ld_valid [NUM_NODE+1];
    logic [COMMAND_WIDTH-1:0] w_ld_tag   [NUM_NODE+1];
    logic [DATA_WIDTH-1:0]    w_ld_data  [NUM_NODE+1];

    logic                     w_inj;
    logic                     w_unused_tail;

    // Injection: i_en gates only new packets; a refused cycle is a bubble.
    assign w_inj         = i_valid & i_en;
    assign w_ld_valid[0] = w_inj;
    assign w_ld_tag[0]   = w_inj ? i_cmd      : '0;
    assign w_ld_data[0]  = w_inj ? i_data_bus : '0;

    generate
        for (genvar k = 0; k < NUM_NODE; k++) begin : g_node
            linear_network_node #(
                .DATA_WIDTH    (DATA_WIDTH),
                .COMMAND_WIDTH (COMMAND_WIDTH),
                .NODE_ID       (k)
            ) u_node (
                .clk         (clk),
                .rst         (rst),
                .i_valid     (w_ld_valid[k]),
                .i_tag       (w_ld_tag[k]),
                .i_data      (w_ld_data[k]),
                .o_dlv_valid (o_valid[k]),
                .o_dlv_data  (o_data_bus[k*DATA_WIDTH +: DATA_WIDTH]),
                .o_fwd_valid (w_ld_valid[k+1]),
                .o_fwd_tag   (w_ld_tag[k+1]),
                .o_fwd_data  (w_ld_data[k+1])
            );
        end : g_node
    endgenerate

    // In-range tags always stop by the last node, so its forward path is dead.
    assign w_unused_tail = ^{w_ld_valid[NUM_NODE], w_ld_tag[NUM_NODE], w_ld_data[NUM_NODE]};

endmodule : linear_network_unicast_seq_1x16
`default_nettype wire

// File: tb/tb_linear_network_unicast_seq_1x16.sv
`default_nettype none
// ============================================================================
// Module      : tb_linear_network_unicast_seq_1x16
// Description : Self-checking bench for the 1x16 linear unicast network with
//               directed scenarios and randomized traffic against a
//               delivery-schedule model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_linear_network_unicast_seq_1x16;

    localparam int c_dw = 32;
    localparam int c_nn = 16;
    localparam int c_cw = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 i_valid = 1'b0;
    logic [c_dw-1:0]      i_data_bus = '0;
    logic                 i_en = 1'b0;
    logic [c_cw-1:0]      i_cmd = '0;
    logic [c_nn-1:0]      o_valid;
    logic [c_nn*c_dw-1:0] o_data_bus;

    linear_network_unicast_seq_1x16 u_dut (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (i_valid),
        .i_data_bus (i_data_bus),
        .i_en       (i_en),
        .i_cmd      (i_cmd),
        .o_valid    (o_valid),
        .o_data_bus (o_data_bus)
    );

    always #5 clk = ~clk;

    // Model: every accepted packet becomes a scheduled delivery
    // (edge number at which it appears, node, payload).
    typedef struct {
        int              due;
        int              node;
        logic [c_dw-1:0] data;
    } dlv_t;

    dlv_t q_dlv[$];
    int   cyc     = 0;
    int   n_check = 0;
    int   n_pass  = 0;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_check++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
    endtask

    // Compare both output buses against whatever the model has due now.
    task automatic check_outputs(input string tag);
        logic [c_nn-1:0]      exp_v;
        logic [c_nn*c_dw-1:0] exp_d;
        exp_v = '0;
        exp_d = '0;
        foreach (q_dlv[i]) begin
            if (q_dlv[i].due == cyc) begin
                exp_v[q_dlv[i].node]               = 1'b1;
                exp_d[q_dlv[i].node*c_dw +: c_dw]  = q_dlv[i].data;
            end
        end
        chk({tag, "_valid"}, 512'(o_valid), 512'(exp_v));
        chk({tag, "_data"},  512'(o_data_bus), 512'(exp_d));
    endtask

    // One clock: capture into model, advance, check, retire old entries.
    task automatic tick(input string tag);
        dlv_t keep[$];
        if (rst) q_dlv.delete();
        else if (i_valid && i_en)
            q_dlv.push_back('{due: cyc + 1 + int'(i_cmd), node: int'(i_cmd), data: i_data_bus});
        @(posedge clk);
        cyc++;
        #1;
        check_outputs(tag);
        foreach (q_dlv[i]) if (q_dlv[i].due > cyc) keep.push_back(q_dlv[i]);
        q_dlv = keep;
    endtask

    task automatic send(input logic [c_cw-1:0] cmd, input logic [c_dw-1:0] data, input string tag);
        i_valid    = 1'b1;
        i_en       = 1'b1;
        i_cmd      = cmd;
        i_data_bus = data;
        tick(tag);
    endtask

    task automatic idle(input int n, input string tag);
        i_valid = 1'b0;
        i_en    = 1'b0;
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    initial begin
        // Reset: outputs clear immediately, without a clock edge.
        i_valid    = 1'b1;
        i_en       = 1'b0;
        i_data_bus = 32'h1234_5678;
        #2 rst = 1'b1;
        #1;
        chk("rst_async_valid", 512'(o_valid), 512'(0));
        chk("rst_async_data",  512'(o_data_bus), 512'(0));
        for (int i = 0; i < 3; i++) tick("rst_hold");
        rst = 1'b0;
        for (int i = 0; i < 3; i++) tick("rst_release");

        // Single unicast to node 1.
        send(4'd1, 32'hAAAA_AAAA, "uni1");
        idle(4, "uni1");

        // Far node 15.
        send(4'd15, 32'hBBBB_BBBB, "far15");
        idle(18, "far15");

        // Gating: one real packet to 14, then refused injections to 14.
        send(4'd14, 32'hCAFE_0014, "gate");
        i_valid = 1'b1;
        i_en    = 1'b0;
        i_cmd   = 4'd14;
        for (int i = 0; i < 18; i++) begin
            i_data_bus = $urandom;
            tick("gate");
        end

        // Streaming with a data change midway.
        send(4'd0, 32'hAAAA_AAAA, "stream");
        send(4'd1, 32'hAAAA_AAAA, "stream");
        send(4'd2, 32'hBBBB_BBBB, "stream");
        send(4'd3, 32'hBBBB_BBBB, "stream");
        idle(6, "stream");

        // Mid-flight reset kills a packet headed for node 15.
        send(4'd15, 32'hDEAD_BEEF, "midrst");
        idle(5, "midrst");
        rst = 1'b1;
        q_dlv.delete();
        #1;
        chk("midrst_async_valid", 512'(o_valid), 512'(0));
        chk("midrst_async_data",  512'(o_data_bus), 512'(0));
        idle(2, "midrst");
        rst = 1'b0;
        idle(18, "midrst_after");

        // Randomized traffic, dense enough for multi-hot deliveries.
        for (int i = 0; i < 400; i++) begin
            i_valid    = ($urandom_range(0, 3) != 0);
            i_en       = ($urandom_range(0, 4) != 0);
            i_cmd      = c_cw'($urandom_range(0, c_nn - 1));
            i_data_bus = $urandom;
            tick("rand");
        end
        idle(18, "drain");

        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end

    // Watchdog against a stalled run.
    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
        $fatal(1, "timeout");
    end

endmodule : tb_linear_network_unicast_seq_1x16
`default_nettype wire
